stream_demux: RTL

Registered, frame-aware 1-to-NUM_PORTS stream demultiplexer with valid/ready flow control, broadcast mode and invalid-destination drop. It sits between the switch ingress lookup and the per-port egress FIFOs of the Ethernet switch. It replaces the purely combinational 4-way demux with a parametrised, back-pressured, packet-atomic router.

---
 rtl/stream_demux_pkg.sv | 18 +
 rtl/demux_out_reg.sv | 39 +++
 rtl/stream_demux.sv | 135 +++++++++++++
 3 files changed

// File: rtl/stream_demux_pkg.sv
// rtl/stream_demux_pkg.sv - shared state type and select helper for stream_demux
package stream_demux_pkg;

    // Routing state of the frame currently crossing the demux.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        UNI   = 2'd1,
        BCAST = 2'd2,
        DROP  = 2'd3
    } state_e;

    // A select value only names a real port when it is below the port count;
    // with a non-power-of-two port count the top codes are unroutable.
    function automatic logic sel_in_range(input int sel, input int num_ports);
        return sel < num_ports;
    endfunction

endpackage

// File: rtl/demux_out_reg.sv
// rtl/demux_out_reg.sv - one-entry valid/ready egress register for one demux port
// Ports: clk, rst_n (async, active-low); load/data/last capture a beat;
// ready is the downstream accept; q_data/q_last/q_valid drive the egress;
// free tells the router this register can take a beat this cycle.
module demux_out_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic             last,
    input  logic             ready,
    output logic [WIDTH-1:0] q_data,
    output logic             q_last,
    output logic             q_valid,
    output logic             free
);

    // Empty, or the held beat leaves this cycle, so a new beat can take its place.
    assign free = !q_valid || ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_data  <= '0;
            q_last  <= 1'b0;
            q_valid <= 1'b0;
        end else if (load) begin
            // A load in the same cycle as a drain replaces the departing beat.
            q_data  <= data;
            q_last  <= last;
            q_valid <= 1'b1;
        end else if (ready) begin
            // Payload is kept on drain so out_data shows the last loaded beat.
            q_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/stream_demux.sv
// rtl/stream_demux.sv - frame-aware 1-to-NUM_PORTS stream demux with broadcast and drop
// Ports: clk, rst_n (async, active-low); ingress in_data/in_valid/in_last with
// in_sel/in_bcast routing sampled on the first beat, in_ready back-pressure;
// per-port egress out_data/out_valid/out_last/out_ready; drop_count of
// frames discarded for an unroutable destination (saturating).
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int NUM_PORTS = 4,
    parameter int SEL_W     = $clog2(NUM_PORTS),
    parameter int CNT_W     = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [WIDTH-1:0]                in_data,
    input  logic                            in_valid,
    input  logic                            in_last,
    input  logic [SEL_W-1:0]                in_sel,
    input  logic                            in_bcast,
    output logic                            in_ready,
    output logic [NUM_PORTS-1:0][WIDTH-1:0] out_data,
    output logic [NUM_PORTS-1:0]            out_valid,
    output logic [NUM_PORTS-1:0]            out_last,
    input  logic [NUM_PORTS-1:0]            out_ready,
    output logic [CNT_W-1:0]                drop_count
);

    state_e                  state;
    state_e                  state_nxt;
    logic [SEL_W-1:0]        dest;
    logic [NUM_PORTS-1:0]    port_free;
    logic [NUM_PORTS-1:0]    load;
    logic [2**SEL_W-1:0]     free_pad;
    logic                    all_free;
    logic                    acc;
    logic                    route_uni;
    logic                    route_bcast;
    logic                    route_drop;
    logic [SEL_W-1:0]        route_sel;

    // Unroutable select codes index zero here; they are never used for
    // unicast, but the padding keeps the variable index in range.
    always_comb begin
        free_pad                = '0;
        free_pad[NUM_PORTS-1:0] = port_free;
    end

    assign all_free = &port_free;

    // Routing of the beat presented now: decided from in_sel/in_bcast on the
    // first beat, from the latched frame state afterwards.
    always_comb begin
        route_uni   = 1'b0;
        route_bcast = 1'b0;
        route_drop  = 1'b0;
        route_sel   = dest;
        case (state)
            IDLE: begin
                route_sel = in_sel;
                if (in_bcast) begin
                    route_bcast = 1'b1;
                end else if (sel_in_range(int'(in_sel), NUM_PORTS)) begin
                    route_uni = 1'b1;
                end else begin
                    route_drop = 1'b1;
                end
            end
            UNI:     route_uni   = 1'b1;
            BCAST:   route_bcast = 1'b1;
            DROP:    route_drop  = 1'b1;
            default: route_drop  = 1'b1;
        endcase
    end

    // in_valid deliberately takes no part here; drop frames never stall.
    assign in_ready = rst_n && ((route_uni && free_pad[route_sel]) ||
                                (route_bcast && all_free) ||
                                route_drop);

    assign acc = in_valid && in_ready;

    always_comb begin
        state_nxt = state;
        if (acc) begin
            if (in_last) begin
                state_nxt = IDLE;
            end else if (state == IDLE) begin
                if (route_bcast) begin
                    state_nxt = BCAST;
                end else if (route_uni) begin
                    state_nxt = UNI;
                end else begin
                    state_nxt = DROP;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            dest       <= '0;
            drop_count <= '0;
        end else begin
            state <= state_nxt;
            if (acc && state == IDLE) begin
                dest <= in_sel;
            end
            if (acc && state == IDLE && route_drop && drop_count != '1) begin
                drop_count <= drop_count + CNT_W'(1);
            end
        end
    end

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        assign load[i] = acc && (route_bcast || (route_uni && route_sel == SEL_W'(i)));

        demux_out_reg #(
            .WIDTH(WIDTH)
        ) u_out_reg (
            .clk    (clk),
            .rst_n  (rst_n),
            .load   (load[i]),
            .data   (in_data),
            .last   (in_last),
            .ready  (out_ready[i]),
            .q_data (out_data[i]),
            .q_last (out_last[i]),
            .q_valid(out_valid[i]),
            .free   (port_free[i])
        );
    end

endmodule
